// File: rtl/game_ctrl_pkg.sv
// Shared types and constants for the game sequencer.
// State, overlay and key encodings used by game_ctrl and its sub-block.
package game_pkg;

    typedef enum logic [1:0] {
        ST_TITLE   = 2'd0,
        ST_PLAY    = 2'd1,
        ST_DEAD    = 2'd2,
        ST_RESPAWN = 2'd3
    } state_e;

    localparam logic [1:0] OV_NONE     = 2'd0;
    localparam logic [1:0] OV_TITLE    = 2'd1;
    localparam logic [1:0] OV_GAMEOVER = 2'd2;

    localparam logic [7:0] KEY_SPACE = 8'h29;
    localparam logic [7:0] KEY_R     = 8'h2D;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/game_ctrl_frame_sync.sv
// vsync synchronizer with a registered one-cycle pulse per falling edge.
// Flops reset high so a held reset level never looks like a frame start.
module frame_sync (
    input  logic clk,
    input  logic clrn,
    input  logic vsync,
    output logic frame_tick
);

    logic s1_q;
    logic s2_q;
    logic s3_q;
    logic tick_q;
    logic tick_d;

    always_comb begin
        tick_d = s3_q & ~s2_q;
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            s1_q   <= 1'b1;
            s2_q   <= 1'b1;
            s3_q   <= 1'b1;
            tick_q <= 1'b0;
        end else begin
            s1_q   <= vsync;
            s2_q   <= s1_q;
            s3_q   <= s2_q;
            tick_q <= tick_d;
        end
    end

    assign frame_tick = tick_q;

endmodule

// File: rtl/game_ctrl.sv
// Game sequencer: frame counting, collision latch, key edges and the
// title/respawn/play/dead state machine driving the sprite controls.
module game_ctrl
    import game_pkg::*;
#(
    parameter int unsigned APPLE_NUM      = 13,
    parameter logic [7:0]  KEY_START      = KEY_SPACE,
    parameter logic [7:0]  KEY_RESTART    = KEY_R,
    parameter int unsigned DEAD_FRAMES    = 60,
    parameter int unsigned RESPAWN_FRAMES = 2
) (
    input  logic                 clk,
    input  logic                 clrn,
    input  logic                 vsync,
    input  logic [7:0]           keycode,
    input  logic                 is_kid,
    input  logic [APPLE_NUM-1:0] is_apple,
    output logic                 frame_tick,
    output logic                 update_en,
    output logic                 sprite_rstn,
    output logic [1:0]           overlay,
    output logic [1:0]           state,
    output logic [7:0]           deaths
);

    localparam logic [7:0] DEAD_LAST    = 8'(DEAD_FRAMES - 1);
    localparam logic [7:0] RESPAWN_LAST = 8'(RESPAWN_FRAMES - 1);

    state_e     state_q, state_d;
    logic [7:0] fcnt_q, fcnt_d;
    logic [7:0] key_q, key_d;
    logic [7:0] deaths_q, deaths_d;
    logic       latch_q, latch_d;
    logic       update_en_q, update_en_d;
    logic       sprite_rstn_q, sprite_rstn_d;
    logic [1:0] overlay_q, overlay_d;

    logic overlap;
    logic hit_frame;
    logic start_ev;
    logic restart_ev;

    frame_sync u_frame_sync (
        .clk        (clk),
        .clrn       (clrn),
        .vsync      (vsync),
        .frame_tick (frame_tick)
    );

    always_comb begin
        overlap    = is_kid & (|is_apple);
        hit_frame  = frame_tick & (latch_q | overlap);
        start_ev   = (keycode == KEY_START) && (key_q != KEY_START);
        restart_ev = (keycode == KEY_RESTART) && (key_q != KEY_RESTART);

        state_d  = state_q;
        deaths_d = deaths_q;
        key_d    = keycode;
        latch_d  = frame_tick ? 1'b0 : (latch_q | overlap);

        unique case (state_q)
            ST_TITLE: begin
                if (start_ev) state_d = ST_RESPAWN;
            end
            ST_RESPAWN: begin
                if (frame_tick && fcnt_q == RESPAWN_LAST) state_d = ST_PLAY;
            end
            ST_PLAY: begin
                if (hit_frame) begin
                    state_d  = ST_DEAD;
                    deaths_d = sat_inc8(deaths_q);
                end else if (restart_ev) begin
                    state_d = ST_RESPAWN;
                end
            end
            ST_DEAD: begin
                if (restart_ev) begin
                    state_d = ST_RESPAWN;
                end else if (frame_tick && fcnt_q == DEAD_LAST) begin
                    state_d = ST_TITLE;
                end
            end
        endcase

        if (state_d != state_q) begin
            fcnt_d = 8'd0;
        end else if (frame_tick) begin
            fcnt_d = fcnt_q + 8'd1;
        end else begin
            fcnt_d = fcnt_q;
        end

        // Outputs are decoded from the next state so they flip with it.
        update_en_d   = 1'b0;
        sprite_rstn_d = 1'b0;
        overlay_d     = OV_NONE;
        unique case (state_d)
            ST_TITLE: begin
                overlay_d = OV_TITLE;
            end
            ST_RESPAWN: begin
                overlay_d = OV_NONE;
            end
            ST_PLAY: begin
                update_en_d   = 1'b1;
                sprite_rstn_d = 1'b1;
            end
            ST_DEAD: begin
                sprite_rstn_d = 1'b1;
                overlay_d     = OV_GAMEOVER;
            end
        endcase
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q       <= ST_TITLE;
            fcnt_q        <= 8'd0;
            key_q         <= 8'd0;
            deaths_q      <= 8'd0;
            latch_q       <= 1'b0;
            update_en_q   <= 1'b0;
            sprite_rstn_q <= 1'b0;
            overlay_q     <= OV_TITLE;
        end else begin
            state_q       <= state_d;
            fcnt_q        <= fcnt_d;
            key_q         <= key_d;
            deaths_q      <= deaths_d;
            latch_q       <= latch_d;
            update_en_q   <= update_en_d;
            sprite_rstn_q <= sprite_rstn_d;
            overlay_q     <= overlay_d;
        end
    end

    assign update_en   = update_en_q;
    assign sprite_rstn = sprite_rstn_q;
    assign overlay     = overlay_q;
    assign state       = state_q;
    assign deaths      = deaths_q;

endmodule

// File: tb/tb_game_ctrl.sv
// Bench for game_ctrl: behavioural model compared every cycle, plus
// directed literal checks from the game rules and random stimulus.
module tb_game_ctrl;

    localparam int AN = 13;
    localparam int DF = 60;
    localparam int RF = 2;
    localparam int FRAME_LEN = 8;

    logic          clk;
    logic          clrn;
    logic          vsync;
    logic [7:0]    keycode;
    logic          is_kid;
    logic [AN-1:0] is_apple;
    logic          frame_tick;
    logic          update_en;
    logic          sprite_rstn;
    logic [1:0]    overlay;
    logic [1:0]    state;
    logic [7:0]    deaths;

    int total;
    int bad;
    int pos;

    game_ctrl dut (
        .clk         (clk),
        .clrn        (clrn),
        .vsync       (vsync),
        .keycode     (keycode),
        .is_kid      (is_kid),
        .is_apple    (is_apple),
        .frame_tick  (frame_tick),
        .update_en   (update_en),
        .sprite_rstn (sprite_rstn),
        .overlay     (overlay),
        .state       (state),
        .deaths      (deaths)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: 0 title, 1 play, 2 dead, 3 respawn
    int   m_state;
    int   m_fcnt;
    int   m_deaths;
    int   m_prevkey;
    int   m_fall_age;
    bit   m_latch;
    bit   m_tick;
    bit   m_prev_v;

    always @(posedge clk or negedge clrn) begin : model
        int  ns;
        int  age;
        bit  ov;
        bit  hit;
        bit  st;
        bit  rs;
        int  dn;
        if (!clrn) begin
            m_state    <= 0;
            m_fcnt     <= 0;
            m_deaths   <= 0;
            m_prevkey  <= 0;
            m_fall_age <= 99;
            m_latch    <= 1'b0;
            m_tick     <= 1'b0;
            m_prev_v   <= 1'b1;
        end else begin
            ov  = is_kid && (is_apple != '0);
            hit = m_tick && (m_latch || ov);
            st  = (keycode == 8'h29) && (m_prevkey != 8'h29);
            rs  = (keycode == 8'h2D) && (m_prevkey != 8'h2D);
            ns  = m_state;
            dn  = m_deaths;
            if (m_state == 0) begin
                if (st) ns = 3;
            end else if (m_state == 3) begin
                if (m_tick && m_fcnt == RF - 1) ns = 1;
            end else if (m_state == 1) begin
                if (hit) begin
                    ns = 2;
                    dn = (m_deaths < 255) ? m_deaths + 1 : 255;
                end else if (rs) begin
                    ns = 3;
                end
            end else begin
                if (rs) ns = 3;
                else if (m_tick && m_fcnt == DF - 1) ns = 0;
            end
            if (ns != m_state) m_fcnt <= 0;
            else if (m_tick) m_fcnt <= (m_fcnt + 1) % 256;
            m_state   <= ns;
            m_deaths  <= dn;
            m_latch   <= m_tick ? 1'b0 : (m_latch || ov);
            m_prevkey <= int'(keycode);
            // frame pulse appears three edges after vsync is first seen low
            if (m_prev_v && !vsync) age = 0;
            else age = (m_fall_age < 99) ? m_fall_age + 1 : 99;
            m_fall_age <= age;
            m_tick     <= (age == 2);
            m_prev_v   <= vsync;
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s act=%0d exp=%0d t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        int exp_ov;
        @(negedge clk);
        if (clrn) begin
            exp_ov = (m_state == 0) ? 1 : (m_state == 2) ? 2 : 0;
            chk("m_tick", int'(frame_tick), int'(m_tick));
            chk("m_state", int'(state), m_state);
            chk("m_update", int'(update_en), int'(m_state == 1));
            chk("m_rstn", int'(sprite_rstn),
                int'(m_state == 1 || m_state == 2));
            chk("m_overlay", int'(overlay), exp_ov);
            chk("m_deaths", int'(deaths), m_deaths);
        end
        pos   = (pos + 1) % FRAME_LEN;
        vsync = (pos >= 2);
    endtask

    task automatic wait_ticks(input int n);
        int seen;
        seen = 0;
        for (int i = 0; i < 2000 && seen < n; i++) begin
            step();
            if (frame_tick) seen++;
        end
        if (seen < n) begin
            total++;
            bad++;
            $display("FAIL tick_timeout act=%0d exp=%0d", seen, n);
        end
    endtask

    task automatic chk_reset_vals(input string nm);
        chk({nm, "_state"}, int'(state), 0);
        chk({nm, "_upd"}, int'(update_en), 0);
        chk({nm, "_rstn"}, int'(sprite_rstn), 0);
        chk({nm, "_ov"}, int'(overlay), 1);
        chk({nm, "_deaths"}, int'(deaths), 0);
        chk({nm, "_tick"}, int'(frame_tick), 0);
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        pos      = 2;
        clrn     = 1'b0;
        vsync    = 1'b1;
        keycode  = 8'h00;
        is_kid   = 1'b0;
        is_apple = '0;
        repeat (3) @(negedge clk);
        chk_reset_vals("rst");
        clrn = 1'b1;

        // start key held 5 cycles -> one respawn, then play after 2 frames
        repeat (3) step();
        keycode = 8'h29;
        repeat (5) step();
        chk("start_state", int'(state), 3);
        chk("start_rstn", int'(sprite_rstn), 0);
        keycode = 8'h00;
        wait_ticks(2);
        step();
        chk("play_state", int'(state), 1);
        chk("play_upd", int'(update_en), 1);
        chk("play_rstn", int'(sprite_rstn), 1);

        // mid-frame overlap is latched and consumed on the next tick
        step();
        is_kid   = 1'b1;
        is_apple = 13'h0080;
        step();
        is_kid   = 1'b0;
        is_apple = '0;
        step();
        chk("latch_hold", int'(state), 1);
        wait_ticks(1);
        step();
        chk("dead_state", int'(state), 2);
        chk("dead_deaths", int'(deaths), 1);
        chk("dead_ov", int'(overlay), 2);
        chk("dead_upd", int'(update_en), 0);

        // 60 frames in dead returns to title
        wait_ticks(DF - 1);
        step();
        chk("dead59_state", int'(state), 2);
        wait_ticks(1);
        step();
        chk("title_state", int'(state), 0);
        chk("title_ov", int'(overlay), 1);
        chk("title_deaths", int'(deaths), 1);

        // hit and restart key in the tick cycle: hit wins
        keycode = 8'h29;
        step();
        keycode = 8'h00;
        wait_ticks(2);
        step();
        chk("play2_state", int'(state), 1);
        wait_ticks(1);
        is_kid   = 1'b1;
        is_apple = 13'h0080;
        keycode  = 8'h2D;
        step();
        is_kid   = 1'b0;
        is_apple = '0;
        chk("tie_state", int'(state), 2);
        chk("tie_deaths", int'(deaths), 2);
        step();
        keycode = 8'h00;
        step();
        keycode = 8'h2D;
        step();
        chk("dead_restart", int'(state), 3);
        keycode = 8'h00;
        wait_ticks(2);
        step();
        step();
        keycode = 8'h2D;
        step();
        chk("restart_state", int'(state), 3);
        chk("restart_deaths", int'(deaths), 2);
        keycode = 8'h00;

        // random traffic, model compared every cycle
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(5) == 0) begin
                case ($urandom_range(3))
                    0: keycode = 8'h00;
                    1: keycode = 8'h29;
                    2: keycode = 8'h2D;
                    default: keycode = 8'($urandom);
                endcase
            end
            is_kid   = ($urandom_range(3) == 0);
            is_apple = ($urandom_range(2) == 0) ?
                       AN'(1 << $urandom_range(AN - 1)) : '0;
            step();
        end

        // steer into play, then async reset mid-play
        keycode  = 8'h00;
        is_kid   = 1'b0;
        is_apple = '0;
        wait_ticks(1);
        step();
        keycode = 8'h2D;
        step();
        keycode = 8'h00;
        step();
        keycode = 8'h29;
        step();
        keycode = 8'h00;
        wait_ticks(2);
        step();
        chk("pre_rst_state", int'(state), 1);
        #2 clrn = 1'b0;
        #1 chk_reset_vals("async");
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            vsync = ~vsync;
            chk("rst_notick", int'(frame_tick), 0);
        end
        vsync = 1'b1;
        pos   = 2;
        @(negedge clk);
        clrn = 1'b1;
        step();
        chk_reset_vals("post");

        // saturate the death counter
        keycode = 8'h29;
        step();
        keycode = 8'h00;
        for (int i = 0; i < 256; i++) begin
            wait_ticks(2);
            step();
            is_kid   = 1'b1;
            is_apple = 13'h0001;
            step();
            is_kid   = 1'b0;
            is_apple = '0;
            wait_ticks(1);
            step();
            keycode = 8'h2D;
            step();
            keycode = 8'h00;
        end
        chk("sat_deaths", int'(deaths), 255);
        chk("sat_state", int'(state), 3);
        repeat (4) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/game_ctrl.md
# game_ctrl

Top-level game sequencer for the render path. Watches the scanned-out pixel flags for kid/apple overlap, counts frames from `vsync`, and decodes start/restart keys. Drives the sprite update enable, sprite reset and screen-overlay select, so that kid and apple motion freezes, resets and resumes under one state machine instead of free-running off `clkdiv`. Sits beside `render`, fed by the same `vga_sync`, `kid` and `apple` signals.

## Interface
- `APPLE_NUM`, 13, width of the apple hit vector
- `KEY_START`, 8'h29, keycode that leaves the title screen (space)
- `KEY_RESTART`, 8'h2D, keycode that forces a respawn (R)
- `DEAD_FRAMES`, 60, frames in DEAD before auto-return to TITLE (1..255)
- `RESPAWN_FRAMES`, 2, frames sprites are held in reset (1..255)

Ports:
- `clk` in 1: system clock, single domain.
- `clrn` in 1: reset, asynchronous, active-low.
- `vsync` in 1: active-low sync from `vga_sync`, asynchronous to `clk`.
- `keycode` in 8: current key make code; 0 when idle.
- `is_kid` in 1: kid pixel flag for the current scan position.
- `is_apple` in `APPLE_NUM`: apple pixel flags.
- `frame_tick` out 1: one-cycle pulse per frame.
- `update_en` out 1: sprites may advance position/animation.
- `sprite_rstn` out 1: active-low reset to kid/apple position state.
- `overlay` out 2: 0 none, 1 title, 2 game-over tint.
- `state` out 2: current state, for debug/LEDs.
- `deaths` out 8: death count, saturating at 255.

## Operation
- Frame detect: 2-flop synchronizer on `vsync` (both flops reset to 1), then a falling-edge detect gives `frame_tick`.
- Collision latch: set in any cycle with `is_kid & |is_apple`. On `frame_tick`:
  - `hit_frame = latch | current overlap`.
  - The latch clears to 0 in that cycle.
- Key edges: `start_ev` and `restart_ev` fire for one cycle when `keycode` becomes equal to the key while the previous-cycle `keycode` differed. Holding a key fires once.
- `fcnt`: 8-bit frame counter, cleared on every state entry, incremented on `frame_tick`.
- States and transitions:
  - TITLE(0): `update_en=0`, `sprite_rstn=0`, `overlay=1`. On `start_ev`, go to RESPAWN.
  - RESPAWN(3): `update_en=0`, `sprite_rstn=0`, `overlay=0`. On the `frame_tick` where `fcnt==RESPAWN_FRAMES-1`, go to PLAY. Other keys are ignored.
  - PLAY(1): `update_en=1`, `sprite_rstn=1`, `overlay=0`.
    - `frame_tick & hit_frame` goes to DEAD with `deaths+1` (saturating).
    - Otherwise `restart_ev` goes to RESPAWN with no death counted.
    - Hit wins when both happen in the same cycle.
  - DEAD(2): `update_en=0`, `sprite_rstn=1` (frozen, kid still visible), `overlay=2`.
    - `restart_ev` goes to RESPAWN.
    - Otherwise the `frame_tick` with `fcnt==DEAD_FRAMES-1` goes to TITLE.
    - The key wins on a tie.
- `deaths` is cleared only by `clrn`.
- The collision latch operates in all states. It is only consumed in PLAY.

## Timing
- Reset values:
  - `state`=TITLE, `update_en`=0, `sprite_rstn`=0, `overlay`=1.
  - `deaths`=0, `frame_tick`=0, `fcnt`=0, latch=0.
- `frame_tick` is asserted on the 3rd rising `clk` after `vsync` falls, for exactly 1 cycle.
- All outputs are registered. They change on the same edge that loads the new state (decoded from next-state); there is no combinational input-to-output path.
- `deaths` updates on the same edge as entry to DEAD.
- Key to state change: 1 cycle after the matching `keycode` is registered.
- Reset asserted mid-frame or mid-state returns to the reset values immediately (async). The first `frame_tick` after release needs a real `vsync` fall, not the reset level.

## Structure
- Package `game_pkg` holds:
  - state encodings TITLE/PLAY/DEAD/RESPAWN;
  - overlay codes NONE/TITLE/GAMEOVER;
  - default key codes.
- Sub-module `frame_sync`: `vsync` synchronizer plus falling-edge pulse, with ports `clk`, `clrn`, `vsync`, `frame_tick`.
- The FSM, collision latch, key-edge logic and counters live in `game_ctrl`.

## Test plan
- Reset, then `keycode`=8'h29 for 5 cycles → exactly one transition to RESPAWN; `sprite_rstn`=0. After 2 `vsync` falls → PLAY, `update_en`=1, `sprite_rstn`=1.
- In PLAY, assert `is_kid`=1 with `is_apple[7]`=1 for 1 cycle mid-frame → no change until the next `frame_tick`, then DEAD, `deaths`=1, `overlay`=2, `update_en`=0.
- In DEAD, no keys, 60 `vsync` falls → TITLE on the 60th tick, `overlay`=1; `deaths` stays 1.
- In PLAY, overlap in the same cycle as `frame_tick` and `keycode` going to 8'h2D → DEAD, `deaths` increments (hit priority). A separate run with `keycode` 8'h2D alone → RESPAWN, `deaths` unchanged.
- Force `deaths` to 255 via 256 death cycles → stays 255.
- Pulse `clrn` low mid-PLAY → all outputs return to reset values within the same cycle. Toggling `vsync` with `clrn` low gives no `frame_tick`.
